// File: rtl/csa_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module   : csa_seq_ctrl
// Purpose  : Sequential adder that reuses one 4-bit carry-select slice, one nibble per cycle.
//            Optional macro CSA_SEQ_OVF_EN adds a registered signed-overflow output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csa_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef CSA_SEQ_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_carry;
   logic              r_cout;
   logic [IDXW-1:0]   r_idx;

   logic [3:0]        w_na;
   logic [3:0]        w_nb;
   logic [3:0]        w_s0;
   logic [3:0]        w_s1;
   logic [4:0]        w_rc0;
   logic [4:0]        w_rc1;
   logic [3:0]        w_slice_sum;
   logic              w_slice_co;
   logic              w_last;

   assign w_na   = r_a[{r_idx, 2'b00} +: 4];
   assign w_nb   = r_b[{r_idx, 2'b00} +: 4];
   assign w_last = (r_idx == IDXW'(NIB - 1));

   // Both ripple halves are evaluated speculatively; the live carry picks one.
   always_comb begin
      w_s0     = 4'd0;
      w_s1     = 4'd0;
      w_rc0    = 5'd0;
      w_rc1    = 5'd0;
      w_rc1[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w_s0[i]     = w_na[i] ^ w_nb[i] ^ w_rc0[i];
         w_rc0[i+1]  = (w_na[i] & w_nb[i]) | (w_rc0[i] & (w_na[i] ^ w_nb[i]));
         w_s1[i]     = w_na[i] ^ w_nb[i] ^ w_rc1[i];
         w_rc1[i+1]  = (w_na[i] & w_nb[i]) | (w_rc1[i] & (w_na[i] ^ w_nb[i]));
      end
      w_slice_sum = r_carry ? w_s1 : w_s0;
      w_slice_co  = r_carry ? w_rc1[4] : w_rc0[4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_idx   <= '0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
         end else if (r_state == RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
            r_carry                    <= w_slice_co;
            r_idx                      <= w_last ? '0 : r_idx + IDXW'(1);
            if (w_last) begin
               r_cout <= w_slice_co;
            end
         end
      end
   end

`ifdef CSA_SEQ_OVF_EN
   logic r_ovf;
   logic w_c_msb;

   // Carry into the top bit, recovered from the selected slice's ripple chain.
   assign w_c_msb = r_carry ? w_rc1[3] : w_rc0[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == RUN && w_last) begin
         r_ovf <= w_c_msb ^ w_slice_co;
      end
   end

   assign ovf = r_ovf;
`endif

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == RUN) || (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule

`default_nettype wire
